timer_unit: RTL and testbench
=============================

TIMER_UNIT -- requirements
Module: timer_unit

Interface
REQ-001 Parameter COMPARE_RST, default 32'hFFFF_FFFF, reset value of COMPARE.
REQ-002 Parameter PRESCALE_W, default 8, width of the PRESCALE register.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cs_timer_n  input  1  active-low chip select from the address decoder.
REQ-006 we  input  1  write strobe, qualified by cs_timer_n low.
REQ-007 addr  input  5  byte address within the timer window; addr[1:0] ignored.
REQ-008 wdata  input  32  write data, full-word writes only.
REQ-009 read_data_timer  output  32  read data to the data-side read mux.
REQ-010 irq_timer  output  1  level interrupt request.

Function
REQ-011 Register map (word offsets): 0x00 CTRL, 0x04 COUNT, 0x08 COMPARE, 0x0C STATUS, 0x10 PRESCALE.
REQ-012 CTRL bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN; bits 31:3 read 0.
REQ-013 STATUS bit0 MATCH, sticky, write-1-to-clear; write of 0 has no effect; bits 31:1 read 0.
REQ-014 PRESCALE holds PRESCALE_W bits; upper bits read 0.
REQ-015 Reads are combinational, same cycle: read_data_timer = selected register when cs_timer_n low and we low, else 32'd0.
REQ-016 Unmapped offsets (0x14-0x1C) read 0; writes to them are ignored.
REQ-017 Writes take effect at the rising edge where cs_timer_n=0 and we=1.
REQ-018 Prescaler counter pcnt increments each cycle while EN=1; tick is asserted when pcnt==PRESCALE, and pcnt returns to 0 at that edge.
REQ-019 With PRESCALE=0, tick is asserted every cycle while EN=1.
REQ-020 When EN=0, pcnt is held at 0 and COUNT is frozen.
REQ-021 A write to PRESCALE or to CTRL clears pcnt to 0.
REQ-022 On a tick edge with COUNT==COMPARE: MATCH is set, and COUNT becomes 0 if AUTO_RELOAD=1, else COUNT+1.
REQ-023 On a tick edge with COUNT!=COMPARE: COUNT becomes COUNT+1, modulo 2^32 (0xFFFF_FFFF wraps to 0, with no flag).
REQ-024 A software write to COUNT overrides a tick increment in the same cycle.
REQ-025 A match set overrides a W1C clear of MATCH in the same cycle.
REQ-026 irq_timer = MATCH & IRQ_EN, registered state only, with no combinational path from the bus inputs.
REQ-027 Writing COMPARE does not itself set or clear MATCH.

Reset
REQ-028 While rst_n=0: CTRL=0, COUNT=0, COMPARE=COMPARE_RST, STATUS=0, PRESCALE=0, pcnt=0, irq_timer=0.
REQ-029 Reset asserted mid-count aborts immediately; the first tick after release occurs PRESCALE+1 enabled cycles after EN is written 1.

Structure
REQ-030 Package timer_pkg holds the register offset constants and the CTRL/STATUS bit-index constants.
REQ-031 The prescaler is sub-module timer_prescaler (inputs en, clr, prescale; output tick); all other logic is in timer_unit.

Verification
REQ-032 PRESCALE=0, COMPARE=3, CTRL=0b011 -> COUNT reads 0,1,2,3,0,1 on successive cycles; MATCH=1 after the 3->0 edge.
REQ-033 PRESCALE=2, COMPARE=0xFFFF_FFFF, EN only -> COUNT increments every 3rd cycle; read with cs_timer_n high returns 0.
REQ-034 COUNT=0xFFFF_FFFE, COMPARE=5, EN only -> COUNT goes 0xFFFF_FFFF then 0, MATCH stays 0.
REQ-035 MATCH=1, IRQ_EN=1 -> irq_timer=1; write STATUS=1 -> irq_timer=0 next cycle; W1C in the same cycle as a new match -> MATCH stays 1.
REQ-036 Write COUNT=0x10 on a tick cycle -> COUNT reads 0x10, not 0x11; assert rst_n mid-run -> all registers return to reset values immediately, with no clock edge needed.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the timer block.
//   - Word indices of the memory-mapped registers (byte offset >> 2).
//   - Bit positions inside CTRL and STATUS.
//   - word_index(): converts a byte address into a register word index.
package timer_pkg;

  // Register word indices (byte offsets 0x00, 0x04, 0x08, 0x0C, 0x10)
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_COUNT    = 3'd1;
  localparam logic [2:0] OFF_COMPARE  = 3'd2;
  localparam logic [2:0] OFF_STATUS   = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_IRQ_EN      = 2;

  // STATUS bit positions
  localparam int STATUS_MATCH = 0;

  // Byte address to word index; the two low address bits are don't-care
  function automatic logic [2:0] word_index(input logic [4:0] byte_addr);
    return byte_addr[4:2];
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock into count ticks.
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   prescaler runs while high; counter held at 0 while low
//   clr      in   restart the division period (pcnt back to 0)
//   prescale in   divide value; a tick occurs every prescale+1 enabled cycles
//   tick     out  high in the cycle whose rising edge advances COUNT
module timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] r_pcnt;

  // Tick is decoded from registered state only (pcnt and the PRESCALE
  // register), so it must be visible in the same cycle the COUNT update uses it.
  assign tick = en & (r_pcnt == prescale);

  // Prescale counter: restarts on disable, software restart or period end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
    end else if (!en || clr || tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/timer_unit.sv
// timer_unit: memory-mapped 32-bit timer with compare match and interrupt.
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   cs_timer_n       in   active-low chip select
//   we               in   write strobe (qualified by cs_timer_n low)
//   addr[4:0]        in   byte address inside the timer window
//   wdata[31:0]      in   full-word write data
//   read_data_timer  out  combinational read data (0 when not reading)
//   irq_timer        out  registered level interrupt (MATCH & IRQ_EN)
// Registers: 0x00 CTRL, 0x04 COUNT, 0x08 COMPARE, 0x0C STATUS, 0x10 PRESCALE.
// PRESCALE_W is expected to be in the range 1..32.
module timer_unit #(
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF,
  parameter int          PRESCALE_W  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_timer_n,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] read_data_timer,
  output logic        irq_timer
);

  import timer_pkg::*;

  logic [2:0]            r_ctrl;
  logic [31:0]           r_count;
  logic [31:0]           r_compare;
  logic                  r_match;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_irq;

  logic                  w_wr;
  logic                  w_rd;
  logic [2:0]            w_idx;
  logic                  w_tick;
  logic                  w_hit;
  logic                  w_pcnt_clr;
  logic [2:0]            w_ctrl_nxt;
  logic [31:0]           w_count_nxt;
  logic [31:0]           w_compare_nxt;
  logic                  w_match_nxt;
  logic [PRESCALE_W-1:0] w_prescale_nxt;
  logic [31:0]           w_rdata;
  logic                  w_unused_addr;

  assign w_wr          = ~cs_timer_n & we;
  assign w_rd          = ~cs_timer_n & ~we;
  assign w_idx         = word_index(addr);
  assign w_unused_addr = ^addr[1:0];

  // Reprogramming the divider or the control word restarts the period
  assign w_pcnt_clr = w_wr & ((w_idx == OFF_CTRL) | (w_idx == OFF_PRESCALE));
  assign w_hit      = w_tick & (r_count == r_compare);

  timer_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (r_ctrl[CTRL_EN]),
    .clr      (w_pcnt_clr),
    .prescale (r_prescale),
    .tick     (w_tick)
  );

  // Next-state for all software-visible registers
  always_comb begin
    w_ctrl_nxt     = r_ctrl;
    w_count_nxt    = r_count;
    w_compare_nxt  = r_compare;
    w_match_nxt    = r_match;
    w_prescale_nxt = r_prescale;

    if (w_wr && (w_idx == OFF_CTRL)) begin
      w_ctrl_nxt = wdata[2:0];
    end else begin
      w_ctrl_nxt = r_ctrl;
    end

    // A software COUNT write wins over a tick in the same cycle
    if (w_wr && (w_idx == OFF_COUNT)) begin
      w_count_nxt = wdata;
    end else if (w_tick) begin
      if (w_hit && r_ctrl[CTRL_AUTO_RELOAD]) begin
        w_count_nxt = 32'd0;
      end else begin
        w_count_nxt = r_count + 32'd1;
      end
    end else begin
      w_count_nxt = r_count;
    end

    if (w_wr && (w_idx == OFF_COMPARE)) begin
      w_compare_nxt = wdata;
    end else begin
      w_compare_nxt = r_compare;
    end

    // A new match wins over a write-1-to-clear in the same cycle
    if (w_hit) begin
      w_match_nxt = 1'b1;
    end else if (w_wr && (w_idx == OFF_STATUS) && wdata[STATUS_MATCH]) begin
      w_match_nxt = 1'b0;
    end else begin
      w_match_nxt = r_match;
    end

    if (w_wr && (w_idx == OFF_PRESCALE)) begin
      w_prescale_nxt = wdata[PRESCALE_W-1:0];
    end else begin
      w_prescale_nxt = r_prescale;
    end
  end

  // Register bank; the interrupt flop tracks MATCH & IRQ_EN cycle for cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= 3'd0;
      r_count    <= 32'd0;
      r_compare  <= COMPARE_RST;
      r_match    <= 1'b0;
      r_prescale <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_ctrl     <= w_ctrl_nxt;
      r_count    <= w_count_nxt;
      r_compare  <= w_compare_nxt;
      r_match    <= w_match_nxt;
      r_prescale <= w_prescale_nxt;
      r_irq      <= w_match_nxt & w_ctrl_nxt[CTRL_IRQ_EN];
    end
  end

  // Same-cycle read mux; returns 0 unless a read is in progress
  always_comb begin
    w_rdata = 32'd0;
    if (w_rd) begin
      case (w_idx)
        OFF_CTRL:     w_rdata[2:0] = r_ctrl;
        OFF_COUNT:    w_rdata = r_count;
        OFF_COMPARE:  w_rdata = r_compare;
        OFF_STATUS:   w_rdata[STATUS_MATCH] = r_match;
        OFF_PRESCALE: w_rdata[PRESCALE_W-1:0] = r_prescale;
        default:      w_rdata = 32'd0;
      endcase
    end else begin
      w_rdata = 32'd0;
    end
  end

  assign read_data_timer = w_rdata;
  assign irq_timer       = r_irq;

endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: directed scenarios plus randomized traffic, checked against
// a register-level behavioural model of the timer kept in the bench.
module tb_timer_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs_timer_n;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] read_data_timer;
  logic        irq_timer;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [2:0]  m_ctrl;
  logic [31:0] m_count;
  logic [31:0] m_compare;
  logic        m_match;
  logic [7:0]  m_prescale;
  int          m_pcnt;

  timer_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cs_timer_n      (cs_timer_n),
    .we              (we),
    .addr            (addr),
    .wdata           (wdata),
    .read_data_timer (read_data_timer),
    .irq_timer       (irq_timer)
  );

  always #10 clk = ~clk;

  function automatic void model_reset();
    m_ctrl     = 3'd0;
    m_count    = 32'd0;
    m_compare  = 32'hFFFF_FFFF;
    m_match    = 1'b0;
    m_prescale = 8'd0;
    m_pcnt     = 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] off);
    case (off)
      3'd0:    return {29'd0, m_ctrl};
      3'd1:    return m_count;
      3'd2:    return m_compare;
      3'd3:    return {31'd0, m_match};
      3'd4:    return {24'd0, m_prescale};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_irq();
    return m_match & m_ctrl[2];
  endfunction

  // Apply one rising edge to the model using the bus inputs currently driven,
  // then advance the DUT clock and settle just past the edge.
  task automatic step();
    logic        wr;
    logic [2:0]  off;
    logic        tick;
    logic        hit;
    logic [31:0] n_count;
    logic        n_match;
    wr   = (cs_timer_n == 1'b0) && (we == 1'b1);
    off  = addr[4:2];
    tick = m_ctrl[0] && (m_pcnt == int'(m_prescale));
    hit  = tick && (m_count == m_compare);
    n_count = m_count;
    if (tick) n_count = (hit && m_ctrl[1]) ? 32'd0 : m_count + 32'd1;
    if (wr && off == 3'd1) n_count = wdata;
    n_match = m_match;
    if (wr && off == 3'd3 && wdata[0]) n_match = 1'b0;
    if (hit) n_match = 1'b1;
    if (!m_ctrl[0] || tick || (wr && (off == 3'd0 || off == 3'd4))) m_pcnt = 0;
    else m_pcnt = m_pcnt + 1;
    if (wr && off == 3'd0) m_ctrl = wdata[2:0];
    if (wr && off == 3'd2) m_compare = wdata;
    if (wr && off == 3'd4) m_prescale = wdata[7:0];
    m_count = n_count;
    m_match = n_match;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [31:0] data);
    cs_timer_n = 1'b0;
    we         = 1'b1;
    addr       = {off, 2'($urandom_range(0, 3))};
    wdata      = data;
    step();
    cs_timer_n = 1'b1;
    we         = 1'b0;
  endtask

  task automatic rd(input logic [2:0] off);
    cs_timer_n = 1'b0;
    we         = 1'b0;
    addr       = {off, 2'($urandom_range(0, 3))};
    #1;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    cs_timer_n = 1'b1;
    we         = 1'b0;
    addr       = 5'd0;
    wdata      = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      total++;
      if (read_data_timer !== model_read(3'(i))) begin
        bad++;
        $display("FAIL reset_reg%0d: got %h expected %h", i, read_data_timer, model_read(3'(i)));
      end
    end
    rd(3'd2);
    total++;
    if (read_data_timer !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL reset_compare: got %h expected ffffffff", read_data_timer);
    end
    total++;
    if (irq_timer !== 1'b0) begin
      bad++;
      $display("FAIL reset_irq: got %b expected 0", irq_timer);
    end
    cs_timer_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_auto_reload();
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    bus_write(3'd0, 32'd0);
    bus_write(3'd1, 32'd0);
    bus_write(3'd4, 32'd0);
    bus_write(3'd2, 32'd3);
    bus_write(3'd3, 32'd1);
    bus_write(3'd0, 32'd3);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      rd(3'd1);
      total++;
      if (read_data_timer !== 32'(exp_seq[i])) begin
        bad++;
        $display("FAIL autoreload_count%0d: got %h expected %h", i, read_data_timer, 32'(exp_seq[i]));
      end
      rd(3'd3);
      total++;
      if (read_data_timer !== ((i >= 4) ? 32'd1 : 32'd0)) begin
        bad++;
        $display("FAIL autoreload_match%0d: got %h expected %h", i, read_data_timer, (i >= 4) ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic test_prescale();
    bus_write(3'd0, 32'd0);
    bus_write(3'd1, 32'd0);
    bus_write(3'd2, 32'hFFFF_FFFF);
    bus_write(3'd4, 32'd2);
    bus_write(3'd3, 32'd1);
    bus_write(3'd0, 32'd1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) step();
      rd(3'd1);
      total++;
      if (read_data_timer !== 32'(k / 3)) begin
        bad++;
        $display("FAIL prescale_count%0d: got %h expected %h", k, read_data_timer, 32'(k / 3));
      end
    end
    cs_timer_n = 1'b1;
    we         = 1'b0;
    addr       = 5'h04;
    #1;
    total++;
    if (read_data_timer !== 32'd0) begin
      bad++;
      $display("FAIL read_cs_high: got %h expected 0", read_data_timer);
    end
    cs_timer_n = 1'b0;
    we         = 1'b1;
    #1;
    total++;
    if (read_data_timer !== 32'd0) begin
      bad++;
      $display("FAIL read_during_write: got %h expected 0", read_data_timer);
    end
    cs_timer_n = 1'b1;
    we         = 1'b0;
  endtask

  task automatic test_wrap();
    bus_write(3'd0, 32'd0);
    bus_write(3'd2, 32'd5);
    bus_write(3'd4, 32'd0);
    bus_write(3'd3, 32'd1);
    bus_write(3'd1, 32'hFFFF_FFFE);
    bus_write(3'd0, 32'd1);
    step();
    rd(3'd1);
    total++;
    if (read_data_timer !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_max: got %h expected ffffffff", read_data_timer);
    end
    step();
    rd(3'd1);
    total++;
    if (read_data_timer !== 32'd0) begin
      bad++;
      $display("FAIL wrap_zero: got %h expected 0", read_data_timer);
    end
    rd(3'd3);
    total++;
    if (read_data_timer !== 32'd0) begin
      bad++;
      $display("FAIL wrap_no_match: got %h expected 0", read_data_timer);
    end
  endtask

  task automatic test_irq_w1c();
    bus_write(3'd0, 32'd0);
    bus_write(3'd1, 32'd0);
    bus_write(3'd2, 32'd1);
    bus_write(3'd4, 32'd0);
    bus_write(3'd3, 32'd1);
    bus_write(3'd0, 32'd5);
    step();
    step();
    total++;
    if (irq_timer !== 1'b1) begin
      bad++;
      $display("FAIL irq_set: got %b expected 1", irq_timer);
    end
    bus_write(3'd3, 32'd0);
    rd(3'd3);
    total++;
    if (read_data_timer !== 32'd1) begin
      bad++;
      $display("FAIL w0_no_effect: got %h expected 1", read_data_timer);
    end
    bus_write(3'd3, 32'd1);
    total++;
    if (irq_timer !== 1'b0) begin
      bad++;
      $display("FAIL irq_cleared: got %b expected 0", irq_timer);
    end
    bus_write(3'd0, 32'd0);
    bus_write(3'd1, 32'd7);
    bus_write(3'd2, 32'd7);
    rd(3'd3);
    total++;
    if (read_data_timer !== 32'd0) begin
      bad++;
      $display("FAIL compare_write_no_set: got %h expected 0", read_data_timer);
    end
    bus_write(3'd0, 32'd5);
    bus_write(3'd3, 32'd1);
    rd(3'd3);
    total++;
    if (read_data_timer !== 32'd1) begin
      bad++;
      $display("FAIL match_beats_w1c: got %h expected 1", read_data_timer);
    end
    total++;
    if (irq_timer !== 1'b1) begin
      bad++;
      $display("FAIL irq_after_race: got %b expected 1", irq_timer);
    end
    bus_write(3'd0, 32'd4);
    bus_write(3'd2, 32'd9);
    rd(3'd3);
    total++;
    if (read_data_timer !== 32'd1) begin
      bad++;
      $display("FAIL compare_write_no_clear: got %h expected 1", read_data_timer);
    end
  endtask

  task automatic test_count_override();
    bus_write(3'd0, 32'd0);
    bus_write(3'd4, 32'd0);
    bus_write(3'd2, 32'h11);
    bus_write(3'd3, 32'd1);
    bus_write(3'd1, 32'd5);
    bus_write(3'd0, 32'd5);
    step();
    bus_write(3'd1, 32'h10);
    rd(3'd1);
    total++;
    if (read_data_timer !== 32'h10) begin
      bad++;
      $display("FAIL write_beats_tick: got %h expected 00000010", read_data_timer);
    end
    step();
    step();
    total++;
    if (irq_timer !== 1'b1) begin
      bad++;
      $display("FAIL irq_before_reset: got %b expected 1", irq_timer);
    end
  endtask

  task automatic test_async_reset();
    rd(3'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      rd(3'(i));
      total++;
      if (read_data_timer !== model_read(3'(i))) begin
        bad++;
        $display("FAIL async_reset_reg%0d: got %h expected %h", i, read_data_timer, model_read(3'(i)));
      end
    end
    total++;
    if (irq_timer !== 1'b0) begin
      bad++;
      $display("FAIL async_reset_irq: got %b expected 0", irq_timer);
    end
    cs_timer_n = 1'b1;
    #2;
    rst_n = 1'b1;
    bus_write(3'd4, 32'd2);
    bus_write(3'd0, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      step();
      rd(3'd1);
      total++;
      if (read_data_timer !== ((k == 3) ? 32'd1 : 32'd0)) begin
        bad++;
        $display("FAIL first_tick%0d: got %h expected %h", k, read_data_timer, (k == 3) ? 32'd1 : 32'd0);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  off;
    logic [31:0] data;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        off = 3'($urandom_range(0, 7));
        case (off)
          3'd0:    data = $urandom | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0);
          3'd1:    data = 32'($urandom_range(0, 12));
          3'd2:    data = 32'($urandom_range(0, 12));
          3'd4:    data = ($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 3));
          default: data = $urandom;
        endcase
        bus_write(off, data);
      end else begin
        step();
      end
      for (int i = 0; i < 6; i++) begin
        off = (i == 5) ? 3'($urandom_range(5, 7)) : 3'(i);
        rd(off);
        total++;
        if (read_data_timer !== model_read(off)) begin
          bad++;
          $display("FAIL random_reg%0d_iter%0d: got %h expected %h", off, n, read_data_timer, model_read(off));
        end
      end
      total++;
      if (irq_timer !== model_irq()) begin
        bad++;
        $display("FAIL random_irq_iter%0d: got %b expected %b", n, irq_timer, model_irq());
      end
      cs_timer_n = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_auto_reload();
    test_prescale();
    test_wrap();
    test_irq_w1c();
    test_count_override();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
